// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor. It computes D = A - B one bit per clock,
//   least significant bit first, through a single borrow flip-flop. The result
//   is reported with a start/busy/done handshake.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   start      in   request a subtraction; only looked at in IDLE
//   A          in   WIDTH-bit unsigned minuend, captured on the accepting edge
//   B          in   WIDTH-bit unsigned subtrahend, captured on the accepting edge
//   busy       out  high while bits are being processed (RUN)
//   done       out  one-cycle pulse; D is valid in the same cycle
//   D          out  WIDTH+1-bit result, A - B in two's complement
//                   (D[WIDTH] is the final borrow)
//   dbg_state  out  current FSM state (0=IDLE, 1=RUN, 2=DONE)
//
// Handshake: a request is accepted on the rising edge where start=1 and the
// block is in IDLE. busy is high for the WIDTH following cycles, then done
// pulses for exactly one cycle with D valid. start is ignored while busy or
// done is high; nothing is queued. The earliest next request is sampled in the
// cycle right after the done pulse. D holds its value between done pulses.

module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   D,
  output logic [1:0]       dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   d_q, d_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Full-subtractor cell for the bit currently at the bottom of the shifters.
  logic diff_bit;
  logic bout;

  always_comb begin
    diff_bit = a_q[0] ^ b_q[0] ^ borrow_q;
    bout     = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & borrow_q);
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    d_d      = d_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d      = A;
          b_d      = B;
          borrow_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end

      S_RUN: begin
        a_d      = {1'b0, a_q[WIDTH-1:1]};
        b_d      = {1'b0, b_q[WIDTH-1:1]};
        // Difference bits enter from the MSB side, so after WIDTH shifts
        // bit 0 of the result has reached position 0.
        res_d    = {diff_bit, res_q[WIDTH-1:1]};
        borrow_d = bout;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          // Publish the completed result straight from the last cell so D
          // changes only on entry to DONE.
          d_d     = {bout, diff_bit, res_q[WIDTH-1:1]};
          cnt_d   = '0;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status flags are registered views of the state being entered.
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      d_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      d_q      <= d_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign D         = d_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor (WIDTH=4). Each operation is driven from its
// start cycle and checked cycle by cycle against the documented timing; the
// expected difference is plain integer arithmetic modulo 2^(WIDTH+1).

module tb_serial_subtractor;

  localparam int W   = 4;
  localparam int MOD = 1 << (W + 1);

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W:0]   d_out;
  logic [1:0]   dbg_state;

  int n_assert;
  int n_fail;
  int prev_d;   // value D must hold between done pulses

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .A         (a_in),
    .B         (b_in),
    .busy      (busy),
    .done      (done),
    .D         (d_out),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W:0] exp_q[$];

  function automatic int ref_sub(input int a, input int b);
    return (a - b + MOD) % MOD;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle cycles with start low: nothing may happen.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b0;
      a_in  = W'($urandom);
      b_in  = W'($urandom);
      tick();
      chk("idle_busy", int'(busy), 0);
      chk("idle_done", int'(done), 0);
      chk("idle_d", int'(d_out), prev_d);
    end
  endtask

  // Called in a cycle where the DUT is IDLE. Drives start with a/b (cycle 0),
  // checks cycles 1..W+1, and returns in cycle W+2 with start = hold.
  // In cycle 2 a competing request (1-1) is always presented; it must be ignored.
  task automatic op(input int a, input int b, input bit hold);
    logic [W:0] exp;
    start = 1'b1;
    a_in  = W'(a);
    b_in  = W'(b);
    exp_q.push_back((W+1)'(ref_sub(a, b)));
    tick();
    for (int k = 1; k <= W + 1; k++) begin
      if (k <= W) begin
        chk($sformatf("run_busy_c%0d", k), int'(busy), 1);
        chk($sformatf("run_done_c%0d", k), int'(done), 0);
        chk($sformatf("run_d_hold_c%0d", k), int'(d_out), prev_d);
      end else begin
        exp = exp_q.pop_front();
        chk("done_busy", int'(busy), 0);
        chk("done_pulse", int'(done), 1);
        chk($sformatf("result_%0d_minus_%0d", a, b), int'(d_out), int'(exp));
        prev_d = int'(exp);
      end
      if (k == 2) begin
        start = 1'b1;
        a_in  = W'(1);
        b_in  = W'(1);
      end else begin
        start = hold ? 1'b1 : 1'($urandom_range(0, 1));
        a_in  = W'($urandom);
        b_in  = W'($urandom);
      end
      tick();
    end
    chk("after_done_low", int'(done), 0);
    chk("after_busy_low", int'(busy), 0);
    chk("after_d_hold", int'(d_out), prev_d);
    start = hold;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    n_assert = 0;
    n_fail   = 0;
    prev_d   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    a_in     = '0;
    b_in     = '0;
    tick();
    tick();
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_d", int'(d_out), 0);
    chk("reset_state", int'(dbg_state), 0);
    rst = 1'b0;
    idle(2);

    // Basic cases.
    op(9, 3, 1'b0);
    chk("basic_9_3", prev_d, 5'b00110);
    idle(1);
    op(3, 5, 1'b0);
    chk("neg_3_5", prev_d, 5'b11110);
    idle(1);
    op(0, 15, 1'b0);
    chk("neg_0_15", prev_d, 5'b10001);
    idle(1);
    op(15, 15, 1'b0);
    chk("zero_15_15", prev_d, 5'b00000);
    idle(2);

    // start held high: back-to-back results every W+2 cycles.
    op(7, 2, 1'b1);
    op(7, 2, 1'b1);
    op(7, 2, 1'b0);
    chk("held_7_2", prev_d, 5'b00101);
    idle(1);

    // Second request in cycle 2 (inside op) must not disturb 12-4.
    op(12, 4, 1'b0);
    chk("ignore_second_start", prev_d, 5'b01000);
    idle(1);

    // Reset mid-operation.
    start = 1'b1;
    a_in  = W'(10);
    b_in  = W'(6);
    tick();                    // cycle 1
    start = 1'b0;
    tick();                    // cycle 2
    chk("pre_rst_busy", int'(busy), 1);
    tick();                    // cycle 3
    rst = 1'b1;
    tick();                    // cycle 4
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_done", int'(done), 0);
    chk("rst_mid_d", int'(d_out), 0);
    chk("rst_mid_state", int'(dbg_state), 0);
    rst    = 1'b0;
    prev_d = 0;
    idle(W + 2);               // no done pulse may follow
    op(10, 6, 1'b0);
    chk("after_rst_10_6", prev_d, 5'b00100);

    // Exhaustive sweep, random order of gaps.
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        idle($urandom_range(0, 2));
        op(a, b, 1'b0);
      end
    end
    idle(2);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Multi-cycle bit-serial subtractor. It computes D = A − B one bit per clock through a single borrow flip-flop, and reports the result with a start/busy/done handshake. It is the subtraction counterpart of the team's ripple-carry adder. It serves datapaths that trade latency for area, such as decrementers, comparators and the future ALU's SUB path.

## Interface
Parameters:
- WIDTH, 4, operand width in bits; legal range 2..16.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a subtraction; sampled only in IDLE.
- A  in  WIDTH  minuend, unsigned; captured on the accepting edge.
- B  in  WIDTH  subtrahend, unsigned; captured on the accepting edge.
- busy  out  1  high while bits are being processed (RUN).
- done  out  1  one-cycle pulse; D is valid in the same cycle.
- D  out  WIDTH+1  result. D[WIDTH-1:0] holds the difference bits. D[WIDTH] holds the final borrow. The whole field is A−B in (WIDTH+1)-bit two's complement.

## Operation
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - start=1 → latch A and B into shift registers, clear borrow, clear the bit counter, go to RUN.
  - start=0 → stay in IDLE.
- RUN: one bit i per cycle, LSB first (i = 0..WIDTH−1).
  - Difference bit: d = a_i ^ b_i ^ bin.
  - Borrow out: bout = (~a_i & b_i) | (~(a_i ^ b_i) & bin).
  - d is shifted into the result register from the MSB side. bout is stored in the borrow flip-flop.
  - When the counter reaches WIDTH−1, the last bit is processed. The final bout is written to D[WIDTH], then the state goes to DONE.
- DONE: done=1 for exactly one cycle, then unconditional return to IDLE.
- start is ignored in RUN and DONE; there is no queuing. A and B may change freely after the accepting edge.
- D holds its last result until the DONE cycle of the next operation. It does not change during RUN; shifting happens in an internal register that is copied to D on entry to DONE.
- Width rule: no overflow is possible. The (WIDTH+1)-bit result covers −(2^WIDTH−1)..(2^WIDTH−1).
- Reset, including mid-operation: state=IDLE, busy=0, done=0, D=0, borrow=0, counter=0. Any in-flight operation is discarded with no done pulse.

## Timing
- Cycle 0 = the cycle in which start=1 is sampled high in IDLE.
- Cycles 1..WIDTH: busy=1, done=0. Bit i is processed at the end of cycle i+1.
- Cycle WIDTH+1: busy=0, done=1, D valid.
- Cycle WIDTH+2: IDLE. The earliest next start is sampled here, giving a throughput of one result per WIDTH+2 cycles.
- Latency from start sample to done: WIDTH+1 cycles (5 for WIDTH=4).
- busy and done are never high together.
- rst asserted in any cycle takes effect at that edge. Outputs show reset values in the following cycle.

## Test plan
- WIDTH=4, A=9, B=3, start pulse → busy high in cycles 1–4; done=1 in cycle 5 with D=5'b00110; done low in cycle 6.
- A=3, B=5 → D=5'b11110 (−2). A=0, B=15 → D=5'b10001 (−15). A=15, B=15 → D=5'b00000.
- start held high continuously with A=7, B=2 → one result every 6 cycles: done pulses in cycles 5, 11, … each with D=5'b00101; no start accepted while busy or done is high.
- Start A=12, B=4; pulse start again in cycle 2 with A=1, B=1 → second start ignored; D=5'b01000 in cycle 5.
- Start A=10, B=6; assert rst in cycle 3 → busy=0, done=0, D=0 from cycle 4; no done pulse follows. A new start after reset gives a correct result (A=10, B=6 → 5'b00100).
- Exhaustive sweep of all 256 A/B pairs → D equals (A−B) mod 32 for every pair, each checked on its done pulse.
